// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with a frame-synchronous display shadow.
// A new word is captured into pending and only promoted to the shown shadow at a frame wrap.
module seven_seg_scanner #(
    parameter int unsigned DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    output logic [3:0]  anode,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PcntMax = PW'(DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_q, pend_d;
    logic [3:0]    anode_q, anode_d;
    logic [3:0]    digit_q, digit_d;
    logic          frame_done_q, frame_done_d;
    logic          tick;
    logic          wrap;

    assign tick = en && (pcnt_q == PcntMax);
    assign wrap = tick && (idx_q == 2'd3);

    always_comb begin
        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        if (tick) begin
            pcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end else if (en) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    // A load on the wrap edge bypasses pending so it shows from the first slot of the new frame.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        if (wrap) begin
            if (load) begin
                shadow_d = din;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                shadow_d = pending_q;
                pend_d   = 1'b0;
            end
        end else if (load) begin
            pending_d = din;
            pend_d    = 1'b1;
        end
    end

    // Outputs are computed from post-edge state so the registers carry no extra lag.
    always_comb begin
        anode_d = 4'b1111;
        digit_d = digit_q;
        if (en) begin
            unique case (idx_d)
                2'd0: begin
                    anode_d = 4'b1110;
                    digit_d = shadow_d[3:0];
                end
                2'd1: begin
                    anode_d = 4'b1101;
                    digit_d = shadow_d[7:4];
                end
                2'd2: begin
                    anode_d = 4'b1011;
                    digit_d = shadow_d[11:8];
                end
                default: begin
                    anode_d = 4'b0111;
                    digit_d = shadow_d[15:12];
                end
            endcase
        end
        frame_done_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q       <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            pending_q    <= 16'h0000;
            pend_q       <= 1'b0;
            anode_q      <= 4'b1111;
            digit_q      <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            anode_q      <= anode_d;
            digit_q      <= digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign digit      = digit_q;
    assign frame_done = frame_done_q;

endmodule
